// File: rtl/i2s_frame_buffer.sv
// Two-bank ping-pong frame buffer between the I2S capture stage and the FFT stage.
// Optional build macro I2S_FRAME_BUFFER_LEFT_ONLY_EN stores the left channel verbatim instead of the mono mix.
module i2s_frame_buffer #(
    parameter int DATA_BITS = 16,
    parameter int FRAME_LEN = 256,
    localparam int ADDR_BITS = $clog2(FRAME_LEN)
) (
    input  logic                 codec_aud_bclk_i,
    input  logic                 rst_n,
    input  logic                 fb_enable_i,
    output logic                 i2s_get_o,
    input  logic [DATA_BITS-1:0] i2s_sample_data_L_i,
    input  logic [DATA_BITS-1:0] i2s_sample_data_R_i,
    input  logic                 i2s_done_i,
    output logic                 fb_ready_o,
    input  logic [ADDR_BITS-1:0] fb_rd_addr_i,
    output logic [DATA_BITS-1:0] fb_rd_data_o,
    input  logic                 fb_release_i,
    output logic                 fb_overrun_o,
    output logic [1:0]           dbg_state,
    output logic                 dbg_wr_bank,
    output logic                 dbg_rd_bank
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(FRAME_LEN - 1);

    state_t               state, state_n;
    logic                 wr_bank, wr_bank_n;
    logic                 rd_bank, rd_bank_n;
    logic [ADDR_BITS-1:0] wr_idx, wr_idx_n;
    logic [1:0]           bank_full, bank_full_n, full_after_rel;
    logic                 overrun_n;
    logic                 release_eff;
    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic [DATA_BITS-1:0] rd_data;
    logic [DATA_BITS-1:0] mem [0:2*FRAME_LEN-1];

`ifdef I2S_FRAME_BUFFER_LEFT_ONLY_EN
    assign wr_data = i2s_sample_data_L_i;
`else
    logic [DATA_BITS:0] mix_sum;
    assign mix_sum = {i2s_sample_data_L_i[DATA_BITS-1], i2s_sample_data_L_i}
                   + {i2s_sample_data_R_i[DATA_BITS-1], i2s_sample_data_R_i};
    // Arithmetic shift right by one of the widened sum, truncated back to DATA_BITS.
    assign wr_data = mix_sum[DATA_BITS:1];
`endif

    // Consumer handshake: fb_ready_o high means the frame in rd_bank may be read at any
    // address with 1-cycle latency; a one-cycle fb_release_i while ready hands the bank back
    // to the writer and moves the reader to the other bank. Release while not ready is ignored.
    assign release_eff = fb_release_i & bank_full[rd_bank];

    always_comb begin
        full_after_rel = bank_full;
        if (release_eff) begin
            full_after_rel[rd_bank] = 1'b0;
        end
    end

    always_comb begin
        state_n     = state;
        wr_bank_n   = wr_bank;
        rd_bank_n   = rd_bank ^ release_eff;
        wr_idx_n    = wr_idx;
        bank_full_n = full_after_rel;
        overrun_n   = fb_overrun_o;
        wr_en       = 1'b0;
        case (state)
            IDLE: begin
                if (fb_enable_i) begin
                    wr_idx_n = '0;
                    if (!full_after_rel[wr_bank]) begin
                        state_n = FILL;
                    end else if (!full_after_rel[~wr_bank]) begin
                        wr_bank_n = ~wr_bank;
                        state_n   = FILL;
                    end else begin
                        state_n = HOLD;
                    end
                end
            end
            FILL: begin
                if (!fb_enable_i) begin
                    state_n  = IDLE;
                    wr_idx_n = '0;
                end else if (i2s_done_i) begin
                    wr_en = 1'b1;
                    if (wr_idx == LAST_IDX) begin
                        bank_full_n[wr_bank] = 1'b1;
                        wr_idx_n             = '0;
                        if (!full_after_rel[~wr_bank]) begin
                            wr_bank_n = ~wr_bank;
                        end else begin
                            state_n = HOLD;
                        end
                    end else begin
                        wr_idx_n = wr_idx + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!fb_enable_i) begin
                    state_n  = IDLE;
                    wr_idx_n = '0;
                end else begin
                    if (i2s_done_i) begin
                        overrun_n = 1'b1;
                    end
                    if (!full_after_rel[~wr_bank]) begin
                        wr_bank_n = ~wr_bank;
                        wr_idx_n  = '0;
                        state_n   = FILL;
                    end
                end
            end
            default: begin
                state_n  = IDLE;
                wr_idx_n = '0;
            end
        endcase
    end

    always_ff @(posedge codec_aud_bclk_i or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wr_bank      <= 1'b0;
            rd_bank      <= 1'b0;
            wr_idx       <= '0;
            bank_full    <= 2'b00;
            fb_overrun_o <= 1'b0;
            i2s_get_o    <= 1'b0;
            rd_data      <= '0;
        end else begin
            state        <= state_n;
            wr_bank      <= wr_bank_n;
            rd_bank      <= rd_bank_n;
            wr_idx       <= wr_idx_n;
            bank_full    <= bank_full_n;
            fb_overrun_o <= overrun_n;
            i2s_get_o    <= fb_enable_i;
            rd_data      <= mem[{rd_bank, fb_rd_addr_i}];
        end
    end

    // Sample storage has no reset so it can map onto block RAM.
    always_ff @(posedge codec_aud_bclk_i) begin
        if (wr_en) begin
            mem[{wr_bank, wr_idx}] <= wr_data;
        end
    end

    assign fb_ready_o   = bank_full[rd_bank];
    assign fb_rd_data_o = rd_data;
    assign dbg_state    = state;
    assign dbg_wr_bank  = wr_bank;
    assign dbg_rd_bank  = rd_bank;

endmodule

// File: tb/tb_i2s_frame_buffer.sv
// Directed bench for i2s_frame_buffer: fill, mix, ping-pong, overrun, enable drop and async reset.
module tb_i2s_frame_buffer;

    localparam int DATA_BITS = 16;
    localparam int FRAME_LEN = 256;
    localparam int ADDR_BITS = $clog2(FRAME_LEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic                 clk;
    logic                 rst_n;
    logic                 fb_enable;
    logic                 i2s_get;
    logic [DATA_BITS-1:0] data_l;
    logic [DATA_BITS-1:0] data_r;
    logic                 done;
    logic                 ready;
    logic [ADDR_BITS-1:0] rd_addr;
    logic [DATA_BITS-1:0] rd_data;
    logic                 release_p;
    logic                 overrun;
    logic [1:0]           dbg_state;
    logic                 dbg_wr_bank;
    logic                 dbg_rd_bank;

    int checks;
    int failures;

    i2s_frame_buffer #(.DATA_BITS(DATA_BITS), .FRAME_LEN(FRAME_LEN)) dut (
        .codec_aud_bclk_i    (clk),
        .rst_n               (rst_n),
        .fb_enable_i         (fb_enable),
        .i2s_get_o           (i2s_get),
        .i2s_sample_data_L_i (data_l),
        .i2s_sample_data_R_i (data_r),
        .i2s_done_i          (done),
        .fb_ready_o          (ready),
        .fb_rd_addr_i        (rd_addr),
        .fb_rd_data_o        (rd_data),
        .fb_release_i        (release_p),
        .fb_overrun_o        (overrun),
        .dbg_state           (dbg_state),
        .dbg_wr_bank         (dbg_wr_bank),
        .dbg_rd_bank         (dbg_rd_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic send_sample(input logic [15:0] l, input logic [15:0] r, input logic rel);
        @(negedge clk);
        data_l    = l;
        data_r    = r;
        done      = 1'b1;
        release_p = rel;
        @(negedge clk);
        done      = 1'b0;
        release_p = 1'b0;
    endtask

    task automatic fill_ramp(input int count, input logic [15:0] base);
        for (int i = 0; i < count; i++) begin
            send_sample(base + 16'(i), base + 16'(i), 1'b0);
        end
    endtask

    task automatic read_at(input int addr, output logic [15:0] data);
        @(negedge clk);
        rd_addr = ADDR_BITS'(addr);
        @(negedge clk);
        data = rd_data;
    endtask

    task automatic release_frame();
        @(negedge clk);
        release_p = 1'b1;
        @(negedge clk);
        release_p = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        fb_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [15:0] rd;
    logic [15:0] mix_l [4];
    logic [15:0] mix_r [4];
    logic [15:0] mix_e [4];

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        fb_enable = 1'b0;
        data_l    = '0;
        data_r    = '0;
        done      = 1'b0;
        rd_addr   = '0;
        release_p = 1'b0;
        mix_l = '{16'h7FFF, 16'h8000, 16'h0003, 16'h1000};
        mix_r = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'hF000};
        mix_e = '{16'h7FFF, 16'h8000, 16'h0001, 16'h0000};

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_get", i2s_get, 0);
        check("rst_ready", ready, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", dbg_state, S_IDLE);
        rst_n = 1'b1;

        // Enable and first frame with L=R=index.
        @(negedge clk);
        fb_enable = 1'b1;
        @(negedge clk);
        check("get_delay", i2s_get, 1);
        check("state_fill", dbg_state, S_FILL);
        fill_ramp(FRAME_LEN - 1, 16'h0000);
        check("ready_early", ready, 0);
        send_sample(16'h00FF, 16'h00FF, 1'b0);
        check("ready_frame1", ready, 1);
        check("wr_bank_flip", dbg_wr_bank, 1);
        read_at(0, rd);   check("f1_addr0", rd, 16'h0000);
        read_at(1, rd);   check("f1_addr1", rd, 16'h0001);
        read_at(255, rd); check("f1_addr255", rd, 16'h00FF);

        // Second frame into bank 1: mix vectors then a ramp; both banks full -> HOLD.
        for (int i = 0; i < 4; i++) send_sample(mix_l[i], mix_r[i], 1'b0);
        for (int i = 4; i < FRAME_LEN; i++) send_sample(16'h0100 + 16'(i), 16'h0100 + 16'(i), 1'b0);
        check("hold_state", dbg_state, S_HOLD);
        check("hold_ready", ready, 1);
        check("hold_no_overrun", overrun, 0);
        send_sample(16'h1234, 16'h1234, 1'b0);
        check("overrun_set", overrun, 1);
        release_frame();
        check("rel_rd_bank", dbg_rd_bank, 1);
        check("rel_ready_stays", ready, 1);
        check("rel_state_fill", dbg_state, S_FILL);
        check("rel_wr_bank", dbg_wr_bank, 0);
        for (int i = 0; i < 4; i++) begin
            read_at(i, rd);
            check($sformatf("mix_%0d", i), rd, mix_e[i]);
        end
        read_at(4, rd); check("f2_addr4", rd, 16'h0104);

        // Refill bank 0 while bank 1 is held.
        fill_ramp(FRAME_LEN, 16'h0200);
        check("refill_hold", dbg_state, S_HOLD);
        release_frame();
        check("refill_rd_bank", dbg_rd_bank, 0);
        read_at(5, rd); check("refill_addr5", rd, 16'h0205);
        check("overrun_sticky", overrun, 1);

        // Release coincides with completion of frame 2.
        do_reset();
        check("rst2_overrun", overrun, 0);
        @(negedge clk);
        fb_enable = 1'b1;
        fill_ramp(FRAME_LEN, 16'h0000);
        fill_ramp(FRAME_LEN - 1, 16'h0100);
        send_sample(16'h01FF, 16'h01FF, 1'b1);
        check("sim_state", dbg_state, S_FILL);
        check("sim_overrun", overrun, 0);
        check("sim_wr_bank", dbg_wr_bank, 0);
        check("sim_rd_bank", dbg_rd_bank, 1);
        check("sim_ready", ready, 1);
        read_at(10, rd); check("sim_f2_addr10", rd, 16'h010A);
        fill_ramp(FRAME_LEN, 16'h0300);
        check("sim_f3_hold", dbg_state, S_HOLD);
        release_frame();
        read_at(7, rd); check("sim_f3_addr7", rd, 16'h0307);

        // Enable drop mid-frame discards the partial frame.
        do_reset();
        @(negedge clk);
        fb_enable = 1'b1;
        fill_ramp(100, 16'h0500);
        fb_enable = 1'b0;
        repeat (2) @(negedge clk);
        check("drop_idle", dbg_state, S_IDLE);
        check("drop_not_ready", ready, 0);
        fb_enable = 1'b1;
        fill_ramp(FRAME_LEN, 16'h0600);
        check("drop_ready", ready, 1);
        read_at(0, rd);   check("drop_addr0", rd, 16'h0600);
        read_at(99, rd);  check("drop_addr99", rd, 16'h0663);
        read_at(100, rd); check("drop_addr100", rd, 16'h0664);
        read_at(255, rd); check("drop_addr255", rd, 16'h06FF);

        // Asynchronous reset between clock edges.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", ready, 0);
        check("arst_get", i2s_get, 0);
        check("arst_rd_data", rd_data, 0);
        check("arst_overrun", overrun, 0);
        check("arst_state", dbg_state, S_IDLE);
        fb_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        release_frame();
        @(negedge clk);
        check("post_rst_release_ready", ready, 0);
        check("post_rst_release_rd_bank", dbg_rd_bank, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2s_frame_buffer.md
Name: i2s_frame_buffer

Overview:
- Downstream of the I2S capture stage; runs in the codec bit-clock domain.
- Gates capture via the I2S get input, mixes each stereo pair to mono and writes samples into a two-bank ping-pong RAM.
- Presents complete frames of FRAME_LEN samples to the spectrum/FFT stage through a ready/release handshake with random-access read.

Parameters:
- DATA_BITS, 16: sample width (signed two's complement), matches the I2S stage.
- FRAME_LEN, 256: samples per frame; power of two, >=4.
- ADDR_BITS (localparam): $clog2(FRAME_LEN).

Ports:
- codec_aud_bclk_i  in  1  codec bit clock; only clock.
- rst_n  in  1  asynchronous, active-low reset.
- fb_enable_i  in  1  capture enable from control logic.
- i2s_get_o  out  1  drives the I2S stage get input.
- i2s_sample_data_L_i  in  DATA_BITS  left sample from the I2S stage.
- i2s_sample_data_R_i  in  DATA_BITS  right sample from the I2S stage.
- i2s_done_i  in  1  one-cycle pulse: L/R pair valid.
- fb_ready_o  out  1  a complete frame is available for reading.
- fb_rd_addr_i  in  ADDR_BITS  read index within the ready frame.
- fb_rd_data_o  out  DATA_BITS  mono sample at fb_rd_addr_i; 1-cycle latency.
- fb_release_i  in  1  one-cycle pulse: consumer is finished with the ready frame.
- fb_overrun_o  out  1  sticky; set when samples were dropped; cleared by reset only.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE; wr_bank=0, rd_bank=0, wr_idx=0, bank_full=2'b00. All outputs 0, including i2s_get_o, fb_ready_o, fb_rd_data_o and fb_overrun_o. RAM contents are not reset.
- i2s_get_o = registered fb_enable_i (1-cycle delay).
- Mono mix: sign-extend L and R to DATA_BITS+1, add, arithmetic shift right 1, keep the low DATA_BITS bits. Examples: 0x7FFF+0x7FFF -> 0x7FFF; 0x8000+0x8000 -> 0x8000; 0x0001+0x0000 -> 0x0000; 0xFFFF+0x0000 -> 0xFFFF.
- FSM states:
  - IDLE: on fb_enable_i=1 -> FILL with wr_idx=0.
  - FILL: each i2s_done_i writes mix into mem[wr_bank][wr_idx], then wr_idx++.
    - At wr_idx==FRAME_LEN-1 the write completes the frame: set bank_full[wr_bank] and reset wr_idx to 0.
    - If bank_full[~wr_bank]==0 after this cycle's release is applied: flip wr_bank and stay in FILL.
    - Otherwise -> HOLD.
  - HOLD: both banks full. Every i2s_done_i is discarded and sets fb_overrun_o. When the release clears bank_full[~wr_bank]: flip wr_bank -> FILL with wr_idx=0.
  - fb_enable_i=0 in FILL or HOLD -> IDLE next cycle. The partial frame is discarded (wr_idx=0). Full banks and the read side are untouched. On re-enable, writing resumes into the current wr_bank if it is free, otherwise into the free bank. If neither bank is free, IDLE -> HOLD.
- Read side:
  - fb_ready_o = bank_full[rd_bank].
  - fb_rd_data_o = mem[rd_bank][fb_rd_addr_i] registered; valid the cycle after the address is presented.
  - fb_release_i with fb_ready_o=1: clear bank_full[rd_bank] and toggle rd_bank. fb_ready_o drops next cycle, or stays high if the other bank is also full.
  - fb_release_i with fb_ready_o=0: ignored.
- Simultaneous events:
  - Release and frame completion in the same cycle: the release is applied first, so the writer swaps banks without entering HOLD.
  - A write and a read to the same bank cannot occur, because writes only target a bank with bank_full=0.
- i2s_done_i is accepted only in FILL; it is ignored in IDLE.
- Reset mid-frame: everything is cleared immediately, and any ready frame is lost.

Optional Feature:
- Macro: I2S_FRAME_BUFFER_LEFT_ONLY_EN.
- Defined: no mixing; the written sample is i2s_sample_data_L_i verbatim and the R input is ignored.
- Undefined: mono mix as specified above.
- Handshake, FSM and timing are identical in both builds.

Test Plan:
- Reset then enable: i2s_get_o=1 one cycle after fb_enable_i. Feed 256 done pulses with L=R=index -> fb_ready_o=1 one cycle after the 256th pulse. Reading addr k returns k one cycle later, for k=0,1,255.
- Mix values: (L,R)=(0x7FFF,0x7FFF) reads 0x7FFF; (0x8000,0x8000) reads 0x8000; (0x0003,0xFFFF) reads 0x0001; (0x1000,0xF000) reads 0x0000.
- Ping-pong: fill 2 frames without release -> FSM=HOLD and fb_ready_o=1. The next done pulse sets fb_overrun_o=1. Release -> rd_bank=1 and fb_ready_o stays 1. The next 256 pulses fill bank 0 again.
- Release in the same cycle as completion of frame 2 (frame 1 ready) -> no HOLD, fb_overrun_o stays 0, and the third frame is written to bank 0.
- Drop fb_enable_i after 100 samples, re-enable, feed 256 -> the ready frame contains only the post-enable samples at addr 0..255.
- Assert rst_n=0 asynchronously mid-frame with fb_ready_o=1 -> all outputs 0 immediately, without waiting for a clock edge. A later fb_release_i is ignored.
